fp_elastic_pipe: RTL and testbench
==================================

Name: fp_elastic_pipe

Overview:
- Parametrised elastic pipeline segment that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers into one reusable block.
- Configurable width, configurable stage depth, valid/ready flow control, bubble collapsing, synchronous flush and an optional registered-ready skid buffer.
- Sits between pipeline stages of the FP CPU. Stall and flush are expressed by handshake signals rather than hard-wired enables.

Parameters:
- WIDTH, 32, payload bits per beat (instruction, PC, operands, control bundle).
- DEPTH, 1, number of register stages (legal range 1..8). Latency is DEPTH cycles.
- REG_READY, 0. When 0, in_ready is combinational from the downstream chain. When 1, in_ready is a register output and is backed by a 1-entry skid buffer.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  final stage holds a beat.
- out_ready  in  1  downstream accepts a beat.
- out_data  out  WIDTH  final-stage payload.
- flush  in  1  synchronous kill of all held beats.
- stage_valid  out  DEPTH  valid bit of each stage; bit 0 is the input stage.
- occupancy  out  $clog2(DEPTH+2)  count of valid stages plus the skid entry.

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valid bits, skid valid and the registered in_ready source clear.
  - Data registers clear to 0, so out_valid=0, out_data=0, stage_valid=0, occupancy=0.
  - in_ready=1 for REG_READY=1, and follows the chain for REG_READY=0.
  - Asserting rst mid-transfer discards every held beat.
- Stage advance enables:
  - Per stage: en[i] = ~valid[i] | en[i+1], with en[DEPTH] = out_ready. A stage loads from its predecessor whenever en[i]=1.
  - Bubbles collapse: an empty stage loads even while the output stalls.
- Handshakes:
  - Input beat transfers when in_valid & in_ready; output beat transfers when out_valid & out_ready.
  - in_valid must not drop and in_data must stay stable until the beat is accepted. The verification engineer asserts this on the environment.
- REG_READY=0:
  - in_ready = en[0] & ~flush.
  - Latency from input handshake to out_valid is DEPTH cycles when nothing stalls.
  - Full-throughput back-to-back transfers, one beat per cycle.
- REG_READY=1:
  - in_ready is the registered value of ~skid_valid.
  - A beat accepted while en[0]=0 is captured in the skid buffer. When en[0]=1 and skid_valid=1, stage 0 loads from the skid and the skid clears.
  - With the skid empty, stage 0 loads directly from in_data, so latency stays DEPTH cycles.
  - Sustains 1 beat/cycle in steady state. After a stall releases, it needs exactly one cycle to reassert in_ready.
- Capacity:
  - Maximum occupancy is DEPTH (REG_READY=0) or DEPTH+1 (REG_READY=1).
  - Full means in_ready=0 while out_ready=0. Empty means out_valid=0.
- Flush:
  - In the cycle flush=1, an output transfer (out_valid & out_ready) still completes.
  - On the next edge, all stage valid bits and skid valid clear.
  - Any input beat handshaked in the flush cycle is dropped. This is only possible with REG_READY=1.
  - Data registers are not cleared. occupancy reads 0 the cycle after flush.
  - If flush=1 and rst=0 together, reset wins.
- Simultaneous events: with the pipe full, in_valid=1 and out_ready=1, the output transfer and the input load happen on the same edge and occupancy is unchanged.
- occupancy:
  - Registered, updated each edge by +1 on an input transfer, -1 on an output transfer and +0 when both occur.
  - Reset to 0 on flush.
  - Must always equal popcount(stage_valid)+skid_valid.

Test Plan:
- Latency: DEPTH=3, REG_READY=0, out_ready=1. Send 0x3F800000 at cycle 0. Required: out_valid=1 with out_data=0x3F800000 at cycle 3 and occupancy=1 during cycles 1-3.
- Throughput and order: DEPTH=4. Stream 0x00000001..0x00000010 with in_valid=1 and out_ready=1. Required: 16 beats emerge in order, one per cycle, no bubbles.
- Backpressure and bubble collapse: DEPTH=4, REG_READY=0. Hold out_ready=0 and inject 2 beats spaced 3 cycles apart. Required: stage_valid=4'b1100 and in_ready=1. Fill to 4 beats, then in_ready=0 and occupancy=4.
- Skid: DEPTH=2, REG_READY=1, out_ready=0. Push 3 beats. Required: occupancy=3 and in_ready=0. Raise out_ready. Required: beats drain in order and in_ready returns 1 one cycle after the first output transfer.
- Flush: DEPTH=3, full pipe with out_ready=1. Assert flush for 1 cycle. Required: the head beat transfers that cycle, next cycle out_valid=0, stage_valid=0, occupancy=0, and no flushed payload ever appears.
- Async reset: DEPTH=3, mid-stream. Drop rst between clock edges. Required: out_valid=0, out_data=0, occupancy=0 immediately, without waiting for an edge. After release, normal streaming resumes.

Source files
------------

// File: rtl/fp_elastic_pipe.sv
// Elastic valid/ready pipeline segment with DEPTH register stages and bubble collapsing.
// Optionally registers in_ready, backing it with a one-entry skid buffer.
module fp_elastic_pipe #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1,
    parameter int REG_READY = 0,
    localparam int OCC_W    = $clog2(DEPTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              flush,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [OCC_W-1:0]  occupancy
);

    logic             valid_reg  [DEPTH];
    logic [WIDTH-1:0] data_reg   [DEPTH];
    logic             prev_valid [DEPTH];
    logic [WIDTH-1:0] prev_data  [DEPTH];
    logic [DEPTH:0]   en;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // A stage may load when it is empty or when the stage after it is moving.
    always_comb begin
        en        = '0;
        en[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            en[i] = ~valid_reg[i] | en[i+1];
        end
    end

    generate
        if (REG_READY != 0) begin : g_skid
            logic             skid_valid_reg;
            logic             skid_valid_next;
            logic             busy_reg;
            logic [WIDTH-1:0] skid_data_reg;

            always_comb begin
                skid_valid_next = skid_valid_reg;
                if (flush) begin
                    skid_valid_next = 1'b0;
                end else if (skid_valid_reg) begin
                    skid_valid_next = ~en[0];
                end else if (in_fire && !en[0]) begin
                    skid_valid_next = 1'b1;
                end
            end

            // busy_reg mirrors the next skid state so in_ready drops the cycle after a capture.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    skid_data_reg  <= '0;
                end else begin
                    skid_valid_reg <= skid_valid_next;
                    busy_reg       <= skid_valid_next;
                    if (!skid_valid_reg && in_fire && !en[0]) begin
                        skid_data_reg <= in_data;
                    end
                end
            end

            assign in_ready  = ~busy_reg;
            assign src_valid = skid_valid_reg | in_fire;
            assign src_data  = skid_valid_reg ? skid_data_reg : in_data;
        end else begin : g_comb
            assign in_ready  = en[0] & ~flush;
            assign src_valid = in_fire;
            assign src_data  = in_data;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign prev_valid[gi] = src_valid;
                assign prev_data[gi]  = src_data;
            end else begin : g_body
                assign prev_valid[gi] = valid_reg[gi-1];
                assign prev_data[gi]  = data_reg[gi-1];
            end

            // Flush only kills valid bits; payload registers keep shifting.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else begin
                    if (flush) begin
                        valid_reg[gi] <= 1'b0;
                    end else if (en[gi]) begin
                        valid_reg[gi] <= prev_valid[gi];
                    end
                    if (en[gi]) begin
                        data_reg[gi] <= prev_data[gi];
                    end
                end
            end

            assign stage_valid[gi] = valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_reg <= '0;
        end else if (flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_reg + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end

    assign occupancy = occ_reg;
    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: tb/tb_fp_elastic_pipe.sv
// Bench for fp_elastic_pipe: four configurations checked each cycle against a queue-of-beats model,
// plus directed scenarios with hand-computed expectations.
module tb_fp_elastic_pipe;

    localparam int NI = 4;
    localparam int DEP [NI] = '{3, 4, 2, 4};
    localparam int RRP [NI] = '{0, 0, 1, 1};

    logic        clk;
    logic        rst;
    logic        iv   [NI];
    logic [31:0] id   [NI];
    logic        ordy [NI];
    logic        fl   [NI];
    logic [NI-1:0] acc_w;
    int          total = 0;
    int          bad   = 0;
    bit          verbose = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k%0d got=%h want=%h", nm, k, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < NI; k++) begin : g
            localparam int D = DEP[k];
            localparam int R = RRP[k];

            logic [D-1:0]              sv;
            logic [$clog2(D+2)-1:0]    oc;
            logic                      ird;
            logic                      ovd;
            logic [31:0]               odd;

            fp_elastic_pipe #(.WIDTH(32), .DEPTH(D), .REG_READY(R)) dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (iv[k]),
                .in_ready   (ird),
                .in_data    (id[k]),
                .out_valid  (ovd),
                .out_ready  (ordy[k]),
                .out_data   (odd),
                .flush      (fl[k]),
                .stage_valid(sv),
                .occupancy  (oc)
            );

            // Model: ordered beats with their stage position (-1 means the skid entry).
            int          qpos [$];
            logic [31:0] qdat [$];
            bit          acc;

            function automatic bit m_ready();
                if (R != 0) return !(qpos.size() > 0 && qpos[qpos.size()-1] < 0);
                return !fl[k] && (qpos.size() < D || ordy[k]);
            endfunction

            always @(posedge clk or negedge rst) begin : mdl
                int ahead;
                int nxt;
                bit inf;
                bit outf;
                if (!rst) begin
                    qpos.delete();
                    qdat.delete();
                    acc = 0;
                end else begin
                    inf  = iv[k] && m_ready();
                    outf = qpos.size() > 0 && qpos[0] == D - 1 && ordy[k];
                    acc  = inf;
                    if (outf) begin
                        void'(qpos.pop_front());
                        void'(qdat.pop_front());
                    end
                    if (fl[k]) begin
                        qpos.delete();
                        qdat.delete();
                    end else begin
                        ahead = D;
                        foreach (qpos[i]) begin
                            nxt = qpos[i] + 1;
                            if (nxt > ahead - 1) nxt = ahead - 1;
                            qpos[i] = nxt;
                            ahead   = nxt;
                        end
                        if (inf) begin
                            qpos.push_back(ahead > 0 ? 0 : -1);
                            qdat.push_back(id[k]);
                        end
                    end
                end
            end

            always @(negedge clk) begin : cmp
                logic [D-1:0] mask;
                bit mv;
                mask = '0;
                foreach (qpos[i]) if (qpos[i] >= 0) mask[qpos[i]] = 1'b1;
                mv = qpos.size() > 0 && qpos[0] == D - 1;
                chk("out_valid", k, 32'(ovd), 32'(mv));
                if (mv) chk("out_data", k, odd, qdat[0]);
                chk("in_ready", k, 32'(ird), 32'(m_ready()));
                chk("stage_valid", k, 32'(sv), 32'(mask));
                chk("occupancy", k, 32'(oc), 32'(qpos.size()));
                if (verbose && ovd && ordy[k]) $display("k%0d beat out data=%h", k, odd);
            end

            assign acc_w[k] = acc;
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1; fl[k] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        #1 rst = 1'b0;
        #1;
        chk("rst_out_valid", 3, 32'(g[3].ovd), 32'd0);
        chk("rst_out_data", 3, g[3].odd, 32'd0);
        chk("rst_occupancy", 3, 32'(g[3].oc), 32'd0);
        chk("rst_stage_valid", 3, 32'(g[3].sv), 32'd0);
        chk("rst_in_ready_reg", 3, 32'(g[3].ird), 32'd1);
        chk("rst_in_ready_comb", 0, 32'(g[0].ird), 32'd1);
        step(); step();
        rst = 1'b1;
        verbose = 1;
        step();

        // Latency, DEPTH=3
        id[0] = 32'h3F80_0000; iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #2;
            chk("lat_occupancy", 0, 32'(g[0].oc), 32'd1);
            chk("lat_out_valid", 0, 32'(g[0].ovd), (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) chk("lat_out_data", 0, g[0].odd, 32'h3F80_0000);
            step();
        end
        #2 chk("lat_drained", 0, 32'(g[0].oc), 32'd0);
        step();

        // Throughput and ordering, DEPTH=4, both ready styles
        for (int c = 0; c < 21; c++) begin
            iv[1] = (c < 16); id[1] = 32'(c + 1);
            iv[3] = (c < 16); id[3] = 32'(c + 1);
            #2;
            if (c >= 4 && c < 20) begin
                chk("thru_valid", 1, 32'(g[1].ovd), 32'd1);
                chk("thru_data", 1, g[1].odd, 32'(c - 3));
            end
            if (c == 20) chk("thru_empty", 1, 32'(g[1].ovd), 32'd0);
            step();
        end

        // Backpressure and bubble collapse, DEPTH=4 comb ready
        ordy[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            iv[1] = (c == 0 || c == 3 || c == 7 || c == 8);
            id[1] = 32'hB0 + 32'(c);
            #2;
            if (c == 7) begin
                chk("bp_stage_valid", 1, 32'(g[1].sv), 32'b1100);
                chk("bp_in_ready", 1, 32'(g[1].ird), 32'd1);
            end
            if (c == 9) begin
                chk("bp_full_ready", 1, 32'(g[1].ird), 32'd0);
                chk("bp_full_occ", 1, 32'(g[1].oc), 32'd4);
            end
            step();
        end
        ordy[1] = 1'b1;
        repeat (6) step();

        // Skid buffer, DEPTH=2 registered ready
        ordy[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv[2] = 1'b1; id[2] = 32'hC0 + 32'(c);
            step();
        end
        iv[2] = 1'b0;
        #2;
        chk("skid_occ", 2, 32'(g[2].oc), 32'd3);
        chk("skid_in_ready", 2, 32'(g[2].ird), 32'd0);
        ordy[2] = 1'b1;
        #1 chk("skid_head", 2, g[2].odd, 32'hC0);
        step();
        #2;
        chk("skid_ready_back", 2, 32'(g[2].ird), 32'd1);
        chk("skid_second", 2, g[2].odd, 32'hC1);
        step();
        #2 chk("skid_third", 2, g[2].odd, 32'hC2);
        step();
        #2 chk("skid_empty", 2, 32'(g[2].ovd), 32'd0);
        step();

        // Flush a full DEPTH=3 pipe
        ordy[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv[0] = 1'b1; id[0] = 32'hF0 + 32'(c);
            step();
        end
        iv[0] = 1'b0; ordy[0] = 1'b1; fl[0] = 1'b1;
        #2;
        chk("flush_head_valid", 0, 32'(g[0].ovd), 32'd1);
        chk("flush_head_data", 0, g[0].odd, 32'hF0);
        chk("flush_occ_before", 0, 32'(g[0].oc), 32'd3);
        step();
        fl[0] = 1'b0;
        #2;
        chk("flush_out_valid", 0, 32'(g[0].ovd), 32'd0);
        chk("flush_stage_valid", 0, 32'(g[0].sv), 32'd0);
        chk("flush_occ", 0, 32'(g[0].oc), 32'd0);
        repeat (4) step();

        // Asynchronous reset mid-stream
        for (int c = 0; c < 5; c++) begin
            iv[0] = 1'b1; id[0] = 32'h50 + 32'(c);
            if (c == 4) begin
                #2 chk("arst_pre_data", 0, g[0].odd, 32'h51);
            end else begin
                step();
            end
        end
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 0, 32'(g[0].ovd), 32'd0);
        chk("arst_out_data", 0, g[0].odd, 32'd0);
        chk("arst_occupancy", 0, 32'(g[0].oc), 32'd0);
        iv[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        iv[0] = 1'b1; id[0] = 32'h77;
        step();
        iv[0] = 1'b0;
        step(); step();
        #2;
        chk("arst_resume_valid", 0, 32'(g[0].ovd), 32'd1);
        chk("arst_resume_data", 0, g[0].odd, 32'h77);
        step();

        // Randomised traffic on all configurations
        verbose = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NI; k++) begin
                if (!iv[k] || acc_w[k]) begin
                    iv[k] = ($urandom_range(0, 99) < 60);
                    id[k] = $urandom;
                end
                ordy[k] = ($urandom_range(0, 99) < 65);
                fl[k]   = ($urandom_range(0, 99) < 3);
            end
            step();
        end
        idle_all();
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
